// File: rtl/window_gen_3x3_pkg.sv
// Shared constants for the 3x3 window / MACC datapath.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package window_gen_3x3_pkg;

  localparam int KERNEL_SIZE = 3;
  localparam int NUM_TAPS    = KERNEL_SIZE * KERNEL_SIZE;
  localparam int PIXEL_WIDTH = 8;

  typedef logic signed [PIXEL_WIDTH-1:0]          pixel_t;
  typedef logic        [NUM_TAPS*PIXEL_WIDTH-1:0] window_t;

  // Bit offset of window lane (r, c); r=0 is the top row, c=0 the left column.
  function automatic int lane_offset(input int r, input int c);
    return PIXEL_WIDTH * (KERNEL_SIZE * r + c);
  endfunction

endpackage

// File: rtl/window_gen_3x3_if.sv
// Pixel-in / window-out bundle between the pixel source, this block and the MACC.
// Latency: n/a (wiring only).
// Backpressure: none; the source pushes with i_valid, the sink must take every o_valid.
interface window_gen_3x3_if
  import window_gen_3x3_pkg::*;
#(
  parameter int DATA_WIDTH = PIXEL_WIDTH
);

  logic [DATA_WIDTH-1:0]          i_data;
  logic                           i_valid;
  logic [NUM_TAPS*DATA_WIDTH-1:0] o_window;
  logic                           o_valid;
  logic                           o_last;

  modport slave (
    input  i_data,
    input  i_valid,
    output o_window,
    output o_valid,
    output o_last
  );

  modport master (
    output i_data,
    output i_valid,
    input  o_window,
    input  o_valid,
    input  o_last
  );

endinterface

// File: rtl/window_gen_3x3_line_buffer.sv
// One image row of pixel storage, indexed by column, read-before-write.
// Latency: rdata is the word stored at addr before this edge's write; the caller registers it.
// Backpressure: none; en=0 leaves the contents untouched.
module window_gen_3x3_line_buffer #(
  parameter int DEPTH      = 8,
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Old word at addr; the window register captures it on the same edge that overwrites it.
  assign rdata = mem[addr];

  // Store the new word on an enabled edge; contents are deliberately never reset.
  always_ff @(posedge clk) begin
    if (en) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/window_gen_3x3.sv
// Raster pixel stream to packed 3x3 "valid" convolution windows for the 9-tap MACC.
// Latency: 1 cycle from the accepting edge to o_valid/o_window/o_last.
// Backpressure: none; i_valid=0 freezes all state, the sink must take every o_valid strobe.
module window_gen_3x3
  import window_gen_3x3_pkg::*;
#(
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8,
  parameter int DATA_WIDTH = PIXEL_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  window_gen_3x3_if.slave  bus
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);

  localparam logic [COL_W-1:0] LAST_COL  = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] FIRST_COL = COL_W'(KERNEL_SIZE - 1);
  localparam logic [ROW_W-1:0] FIRST_ROW = ROW_W'(KERNEL_SIZE - 1);

  logic                  accept;
  logic [COL_W-1:0]      col;
  logic [ROW_W-1:0]      row;
  logic                  emit;
  logic                  frame_end;
  logic [DATA_WIDTH-1:0] lb0_rdata;
  logic [DATA_WIDTH-1:0] lb1_rdata;
  logic [DATA_WIDTH-1:0] win [KERNEL_SIZE][KERNEL_SIZE];
  logic                  valid_q;
  logic                  last_q;
  window_t               window_flat;

  assign accept = bus.i_valid;

  // Only windows fully inside the image are emitted; this gate also hides stale
  // line-buffer rows after reset and stale columns carried over a row wrap.
  assign emit      = (row >= FIRST_ROW) && (col >= FIRST_COL);
  assign frame_end = (row == LAST_ROW) && (col == LAST_COL);

  // Buffer 0 holds the previous row; buffer 1 is fed from buffer 0 so it holds the row before.
  window_gen_3x3_line_buffer #(
    .DEPTH      (IMG_WIDTH),
    .WIDTH      (DATA_WIDTH),
    .ADDR_WIDTH (COL_W)
  ) u_lb0 (
    .clk   (clk),
    .en    (accept),
    .addr  (col),
    .wdata (bus.i_data),
    .rdata (lb0_rdata)
  );

  window_gen_3x3_line_buffer #(
    .DEPTH      (IMG_WIDTH),
    .WIDTH      (DATA_WIDTH),
    .ADDR_WIDTH (COL_W)
  ) u_lb1 (
    .clk   (clk),
    .en    (accept),
    .addr  (col),
    .wdata (lb0_rdata),
    .rdata (lb1_rdata)
  );

  // Raster position of the pixel being offered: column wraps into row, row wraps per frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col == LAST_COL) begin
        col <= '0;
        row <= (row == LAST_ROW) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Shift the 3x3 array left one column per accept; new right column is top/middle/bottom rows.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < KERNEL_SIZE; r++) begin
        for (int c = 0; c < KERNEL_SIZE; c++) begin
          win[r][c] <= '0;
        end
      end
    end else if (accept) begin
      for (int r = 0; r < KERNEL_SIZE; r++) begin
        for (int c = 0; c < KERNEL_SIZE - 1; c++) begin
          win[r][c] <= win[r][c+1];
        end
      end
      win[0][KERNEL_SIZE-1] <= lb1_rdata;
      win[1][KERNEL_SIZE-1] <= lb0_rdata;
      win[2][KERNEL_SIZE-1] <= bus.i_data;
    end
  end

  // One-cycle strobes marking the cycle in which the window registers hold a full window.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= accept && emit;
      last_q  <= accept && emit && frame_end;
    end
  end

  // Pack the array into the MACC lane order, lane 3*r+c, pure transport of the pixel bits.
  always_comb begin
    window_flat = '0;
    for (int r = 0; r < KERNEL_SIZE; r++) begin
      for (int c = 0; c < KERNEL_SIZE; c++) begin
        window_flat[lane_offset(r, c) +: PIXEL_WIDTH] = win[r][c];
      end
    end
  end

  assign bus.o_window = window_flat;
  assign bus.o_valid  = valid_q;
  assign bus.o_last   = last_q;

endmodule

// File: tb/tb_window_gen_3x3.sv
// Directed bench for window_gen_3x3 on a 4x4 image.
// Latency: outputs are checked 1 time unit after every rising edge.
// Backpressure: exercised through i_valid gaps; the DUT has no ready.
module tb_window_gen_3x3;

  localparam int W = 4;
  localparam int H = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int vectors     = 0;
  int miscompares = 0;
  int strobes     = 0;
  int lasts       = 0;
  logic        have_first = 1'b0;
  logic [71:0] first_win  = '0;

  always #5 clk = ~clk;

  window_gen_3x3_if #(.DATA_WIDTH(8)) bus ();

  window_gen_3x3 #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .DATA_WIDTH (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Window whose top-left pixel value is tl, for a frame of consecutive integers.
  function automatic logic [71:0] exp_win(input int tl);
    logic [71:0] w;
    w = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        w[(3*r + c)*8 +: 8] = 8'(tl + W*r + c);
      end
    end
    return w;
  endfunction

  function automatic int lane_sum(input logic [71:0] w);
    int s;
    s = 0;
    for (int k = 0; k < 9; k++) begin
      s = s + int'($signed(w[8*k +: 8]));
    end
    return s;
  endfunction

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check_win(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle, then check the outputs registered by that edge.
  task automatic step(input logic r, input logic v, input logic [7:0] d,
                      input logic ev, input logic el, input logic [71:0] ew,
                      input string tag);
    @(negedge clk);
    rst         = r;
    bus.i_valid = v;
    bus.i_data  = d;
    @(posedge clk);
    #1;
    check_bit({tag, " o_valid"}, bus.o_valid, ev);
    check_bit({tag, " o_last"}, bus.o_last, el);
    if (ev) check_win({tag, " o_window"}, bus.o_window, ew);
    if (r) check_win({tag, " reset o_window"}, bus.o_window, 72'h0);
    if (bus.o_valid) begin
      strobes++;
      if (!have_first) begin
        have_first = 1'b1;
        first_win  = bus.o_window;
      end
    end
    if (bus.o_last) lasts++;
  endtask

  // One frame of W*H pixels: base+1.. or a fixed value, optionally with an idle cycle before each.
  task automatic frame(input int base, input bit stall, input bit fixed,
                       input logic [7:0] fv, input bit macc, input string tag);
    int macc_exp [4] = '{54, 63, 90, 99};
    int k = 0;
    for (int i = 0; i < W*H; i++) begin
      int          row_i = i / W;
      int          col_i = i % W;
      logic [7:0]  pix;
      logic        ev;
      logic        el;
      logic [71:0] ew;
      if (stall) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 72'h0, {tag, " gap"});
      pix = fixed ? fv : 8'(base + i + 1);
      ev  = (row_i >= 2) && (col_i >= 2);
      el  = (i == W*H - 1);
      ew  = fixed ? {9{fv}} : exp_win(base + i + 1 - 2*W - 2);
      step(1'b0, 1'b1, pix, ev, el, ew, tag);
      if (ev && macc) begin
        check_int({tag, " macc sum"}, lane_sum(bus.o_window), macc_exp[k]);
        k++;
      end
    end
  endtask

  initial begin
    bus.i_valid = 1'b0;
    bus.i_data  = 8'h00;

    // Reset state
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 72'h0, "reset0");
    step(1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 72'h0, "reset1");

    // Single frame, back-to-back pixels, with MACC sums for unit weights
    strobes = 0;
    frame(0, 1'b0, 1'b0, 8'h00, 1'b1, "single");
    check_int("single strobes", strobes, 4);
    check_win("single first window", first_win, 72'h0B0A09_070605_030201);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 72'h0, "idle0");

    // Same frame with a gap before every pixel
    strobes = 0;
    frame(0, 1'b1, 1'b0, 8'h00, 1'b0, "stalled");
    check_int("stalled strobes", strobes, 4);

    // Two frames back to back without a bubble
    strobes = 0;
    lasts   = 0;
    frame(0, 1'b0, 1'b0, 8'h00, 1'b0, "frame1");
    frame(16, 1'b0, 1'b0, 8'h00, 1'b0, "frame2");
    check_int("two frame strobes", strobes, 8);
    check_int("two frame o_last", lasts, 2);

    // Partial frame, one reset cycle, then a full frame
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b1, 8'(101 + i), 1'b0, 1'b0, 72'h0, "partial");
    end
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 72'h0, "midreset");
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 72'h0, "postreset");
    strobes = 0;
    frame(0, 1'b0, 1'b0, 8'h00, 1'b1, "afterreset");
    check_int("afterreset strobes", strobes, 4);

    // Signed extreme value carried through untouched
    strobes = 0;
    frame(0, 1'b0, 1'b1, 8'h80, 1'b0, "neg128");
    check_int("neg128 strobes", strobes, 4);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 72'h0, "idle_end");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
